// File: rtl/csr_counters.sv
// csr_counters: mcycle/minstret/mhpmcounter CSRs with mcountinhibit, mhpmevent and read-only user shadows.
// Define RISCX_HPM_COUNTERS_EN to build NUM_HPM hpm counter/event pairs; otherwise that space reads 0.
module csr_counters #(
   parameter int unsigned NUM_HPM = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               csr_en,
   input  logic [1:0]         csr_op,
   input  logic [11:0]        csr_addr,
   input  logic [31:0]        csr_wdata,
   output logic [31:0]        csr_rdata,
   output logic               csr_hit,
   output logic               csr_illegal,
   input  logic               instr_retired,
   input  logic [NUM_HPM-1:0] hpm_event
);
   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_SET   = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   function automatic logic [31:0] inhibit_mask();
      logic [31:0] m;
      m = 32'h0000_0005;
`ifdef RISCX_HPM_COUNTERS_EN
      for (int unsigned k = 0; k < NUM_HPM; k++) m = m | (32'h8 << k);
`endif
      return m;
   endfunction
   localparam logic [31:0] INH_MASK = inhibit_mask();

   logic        sel_cyc, sel_ins, sel_hpm, sel_inh, sel_evt, is_shadow, sel_hi;
   logic        hpm_present, wr_en;
   logic [4:0]  sel_idx;
   logic [31:0] cur, wval, hpm_rd;
   logic [63:0] mcycle, minstret;
   logic [31:0] mcountinhibit;

   assign sel_idx = csr_addr[4:0];
   assign sel_hi  = csr_addr[7];

   // Counter space Bxx/Cxx with bits [6:5]=0 covers x00-x1F and x80-x9F in one decode.
   always_comb begin
      sel_cyc   = 1'b0;
      sel_ins   = 1'b0;
      sel_hpm   = 1'b0;
      sel_inh   = 1'b0;
      sel_evt   = 1'b0;
      is_shadow = 1'b0;
      if ((csr_addr[11:8] == 4'hB || csr_addr[11:8] == 4'hC) && csr_addr[6:5] == 2'b00) begin
         is_shadow = (csr_addr[11:8] == 4'hC);
         sel_cyc   = (sel_idx == 5'd0);
         sel_ins   = (sel_idx == 5'd2);
         sel_hpm   = (sel_idx >= 5'd3) && hpm_present;
      end else if (csr_addr[11:5] == 7'h19) begin
         sel_inh = (sel_idx == 5'd0);
         sel_evt = (sel_idx >= 5'd3) && hpm_present;
      end
   end

   always_comb begin
      cur = '0;
      if (sel_cyc)                 cur = sel_hi ? mcycle[63:32] : mcycle[31:0];
      else if (sel_ins)            cur = sel_hi ? minstret[63:32] : minstret[31:0];
      else if (sel_inh)            cur = mcountinhibit;
      else if (sel_hpm || sel_evt) cur = hpm_rd;
   end

   always_comb begin
      case (csr_op)
         OP_WRITE: wval = csr_wdata;
         OP_SET:   wval = cur | csr_wdata;
         OP_CLEAR: wval = cur & ~csr_wdata;
         default:  wval = cur;
      endcase
   end

   assign csr_hit     = sel_cyc | sel_ins | sel_hpm | sel_inh | sel_evt;
   assign csr_rdata   = cur;
   assign wr_en       = csr_en & csr_hit & ~is_shadow & (csr_op != OP_READ);
   assign csr_illegal = csr_en & csr_hit & is_shadow &
                        ((csr_op == OP_WRITE) |
                         (((csr_op == OP_SET) | (csr_op == OP_CLEAR)) & (csr_wdata != '0)));

   // A write to either half suppresses the increment of the whole 64-bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         mcycle        <= '0;
         minstret      <= '0;
         mcountinhibit <= '0;
      end else begin
         if (wr_en && sel_cyc) begin
            if (sel_hi) mcycle[63:32] <= wval;
            else        mcycle[31:0]  <= wval;
         end else if (!mcountinhibit[0]) begin
            mcycle <= mcycle + 64'd1;
         end
         if (wr_en && sel_ins) begin
            if (sel_hi) minstret[63:32] <= wval;
            else        minstret[31:0]  <= wval;
         end else if (instr_retired && !mcountinhibit[2]) begin
            minstret <= minstret + 64'd1;
         end
         if (wr_en && sel_inh) mcountinhibit <= wval & INH_MASK;
      end
   end

`ifdef RISCX_HPM_COUNTERS_EN
   localparam int unsigned HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
   logic [31:0] hpm_rd_v [HPM_N];

   assign hpm_present = (32'(sel_idx) < NUM_HPM + 32'd3);

   for (genvar k = 0; k < NUM_HPM; k++) begin : g_hpm
      logic [63:0] cnt;
      logic        evt_en;
      logic        sel_me;
      assign sel_me = (sel_idx == 5'(k + 3));
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt    <= '0;
            evt_en <= 1'b0;
         end else begin
            if (wr_en && sel_evt && sel_me) evt_en <= wval[0];
            if (wr_en && sel_hpm && sel_me) begin
               if (sel_hi) cnt[63:32] <= wval;
               else        cnt[31:0]  <= wval;
            end else if (hpm_event[k] && evt_en && !mcountinhibit[k + 3]) begin
               cnt <= cnt + 64'd1;
            end
         end
      end
      assign hpm_rd_v[k] = !sel_me ? '0 :
                           sel_evt ? {31'b0, evt_en} :
                           sel_hi  ? cnt[63:32] : cnt[31:0];
   end
   for (genvar k = NUM_HPM; k < HPM_N; k++) begin : g_pad
      assign hpm_rd_v[k] = '0;
   end

   always_comb begin
      hpm_rd = '0;
      for (int unsigned k = 0; k < HPM_N; k++) hpm_rd = hpm_rd | hpm_rd_v[k];
   end
`else
   logic unused_hpm_event;
   assign unused_hpm_event = ^hpm_event;
   assign hpm_present      = 1'b1;
   assign hpm_rd           = '0;
`endif
endmodule

// File: tb/tb_csr_counters.sv
// tb_csr_counters: directed test-plan sequence then randomized accesses, checked against a 64-bit array model.
module tb_csr_counters;
   localparam int unsigned N_HPM = 2;
`ifdef RISCX_HPM_COUNTERS_EN
   localparam bit HPM_EN = 1'b1;
`else
   localparam bit HPM_EN = 1'b0;
`endif
   localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

   logic             clk = 1'b0;
   logic             rst, csr_en, csr_hit, csr_illegal, instr_retired;
   logic [1:0]       csr_op;
   logic [11:0]      csr_addr;
   logic [31:0]      csr_wdata, csr_rdata;
   logic [N_HPM-1:0] hpm_event;

   csr_counters #(.NUM_HPM(N_HPM)) dut (
      .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
      .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
      .csr_illegal(csr_illegal), .instr_retired(instr_retired), .hpm_event(hpm_event)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0, n_bad = 0;
   logic [63:0] m_cnt [32];
   logic [31:0] m_inh;
   bit          m_evt [32];
   bit          chk_en = 1'b0;
   logic [31:0] last_rdata;
   logic        last_hit, last_ill;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit counter_exists(input int unsigned idx);
      return idx == 0 || idx == 2 || (idx >= 3 && (!HPM_EN || idx < 3 + N_HPM));
   endfunction

   function automatic logic [31:0] inh_mask();
      return 32'h5 | (HPM_EN ? (((32'h1 << N_HPM) - 32'h1) << 3) : 32'h0);
   endfunction

   // kind: 0 counter half, 1 mcountinhibit, 2 mhpmevent
   task automatic m_decode(input logic [11:0] a, output bit hit, output bit sh,
                           output int unsigned kind, output int unsigned idx, output bit hi);
      int unsigned ai;
      ai = a;
      hit = 0; sh = 0; kind = 0; idx = 0; hi = 0;
      if ((ai >= 'hB00 && ai <= 'hB1F) || (ai >= 'hB80 && ai <= 'hB9F) ||
          (ai >= 'hC00 && ai <= 'hC1F) || (ai >= 'hC80 && ai <= 'hC9F)) begin
         sh  = ai >= 'hC00;
         hi  = (ai % 256) >= 128;
         idx = ai % 32;
         hit = counter_exists(idx);
      end else if (ai == 'h320) begin
         hit = 1; kind = 1;
      end else if (ai >= 'h323 && ai <= 'h33F) begin
         kind = 2;
         idx  = ai - 'h320;
         hit  = !HPM_EN || idx < 3 + N_HPM;
      end
   endtask

   function automatic logic [31:0] m_read(input int unsigned kind, input int unsigned idx, input bit hi);
      if (kind == 1) return m_inh;
      if (kind == 2) return {31'b0, m_evt[idx]};
      return hi ? m_cnt[idx][63:32] : m_cnt[idx][31:0];
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) begin
         m_cnt[i] = 64'h0;
         m_evt[i] = 1'b0;
      end
      m_inh = 32'h0;
   endtask

   task automatic step(input bit r, input bit en, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd, input bit ret, input logic [N_HPM-1:0] ev);
      bit hit, sh, hi, exp_ill;
      int unsigned kind, idx;
      logic [31:0] exp_rd, nv;
      bit inc [32];
      rst = r; csr_en = en; csr_op = op; csr_addr = addr; csr_wdata = wd;
      instr_retired = ret; hpm_event = ev;
      #1;
      m_decode(addr, hit, sh, kind, idx, hi);
      exp_rd  = hit ? m_read(kind, idx, hi) : 32'h0;
      exp_ill = en && hit && sh && (op == WR || ((op == ST || op == CL) && wd != 0));
      last_rdata = csr_rdata; last_hit = csr_hit; last_ill = csr_illegal;
      if (chk_en) begin
         check("hit", {31'b0, csr_hit}, {31'b0, hit});
         check("illegal", {31'b0, csr_illegal}, {31'b0, exp_ill});
         check("rdata", csr_rdata, exp_rd);
      end
      if (r) begin
         m_clear();
      end else begin
         for (int i = 0; i < 32; i++) inc[i] = 1'b0;
         inc[0] = !m_inh[0];
         inc[2] = ret && !m_inh[2];
         for (int k = 0; k < N_HPM; k++)
            inc[3+k] = HPM_EN && ev[k] && m_evt[3+k] && !m_inh[3+k];
         if (en && hit && op != RD && !sh) begin
            nv = (op == WR) ? wd : (op == ST) ? (exp_rd | wd) : (exp_rd & ~wd);
            if (kind == 0) begin
               inc[idx] = 1'b0;
               if (idx < 3 || HPM_EN) begin
                  if (hi) m_cnt[idx] = {nv, m_cnt[idx][31:0]};
                  else    m_cnt[idx] = {m_cnt[idx][63:32], nv};
               end
            end else if (kind == 1) begin
               m_inh = nv & inh_mask();
            end else if (HPM_EN) begin
               m_evt[idx] = nv[0];
            end
         end
         for (int i = 0; i < 32; i++) if (inc[i]) m_cnt[i] = m_cnt[i] + 64'd1;
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [11:0] rand_addr();
      case ($urandom_range(0, 27))
         0: return 12'hB00;  1: return 12'hB80;  2: return 12'hB02;  3: return 12'hB82;
         4: return 12'hB03;  5: return 12'hB83;  6: return 12'hB04;  7: return 12'hB84;
         8: return 12'hB05;  9: return 12'hC00; 10: return 12'hC80; 11: return 12'hC02;
        12: return 12'hC82; 13: return 12'hC03; 14: return 12'hC04; 15: return 12'hC05;
        16: return 12'h320; 17: return 12'h323; 18: return 12'h324; 19: return 12'h325;
        20: return 12'hB01; 21: return 12'h321; 22: return 12'hC01; 23: return 12'h33F;
        24: return 12'hB1F; 25: return 12'hC9F; 26: return 12'h320;
         default: return 12'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] rand_wdata();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'hFFFF_FFFE;
         3: return 32'h1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      m_clear();
      step(1, 0, RD, 12'h000, 32'h0, 0, '0);
      chk_en = 1'b1;
      step(1, 1, WR, 12'hB00, 32'h1234, 1, '1);

      for (int i = 0; i < 10; i++) step(0, 0, RD, 12'h000, 32'h0, 0, '0);
      step(0, 1, RD, 12'hB00, 32'h0, 0, '0);  check("tp_b00_idle", last_rdata, 32'hA);
      step(0, 1, RD, 12'hC00, 32'h0, 0, '0);  check("tp_c00_shadow", last_rdata, 32'hB);
      step(0, 1, RD, 12'hB02, 32'h0, 0, '0);  check("tp_b02_zero", last_rdata, 32'h0);

      step(0, 1, WR, 12'hB00, 32'hFFFF_FFFF, 0, '0);
      step(0, 1, WR, 12'hB80, 32'h0, 0, '0);
      step(0, 0, RD, 12'h000, 32'h0, 0, '0);
      step(0, 1, RD, 12'hB00, 32'h0, 0, '0);  check("carry_lo", last_rdata, 32'h0);
      step(0, 1, RD, 12'hB80, 32'h0, 0, '0);  check("carry_hi", last_rdata, 32'h1);

      step(0, 1, WR, 12'h320, 32'h5, 0, '0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, RD, 12'hB02, 32'h0, 1, '0);
         check("inh_b02", last_rdata, 32'h0);
      end
      step(0, 1, CL, 12'h320, 32'h5, 0, '0);
      for (int i = 0; i < 3; i++) step(0, 0, RD, 12'h000, 32'h0, 1, '0);
      step(0, 1, RD, 12'hB02, 32'h0, 0, '0);  check("retire3", last_rdata, 32'h3);

      step(0, 1, WR, 12'hB02, 32'h100, 1, '0);
      step(0, 1, RD, 12'hB02, 32'h0, 0, '0);  check("wr_beats_inc", last_rdata, 32'h100);
      step(0, 1, WR, 12'hC02, 32'h1, 0, '0);  check("shadow_wr_ill", {31'b0, last_ill}, 32'h1);
      step(0, 1, RD, 12'hB02, 32'h0, 0, '0);  check("shadow_no_eff", last_rdata, 32'h100);
      step(0, 1, ST, 12'hC02, 32'h0, 0, '0);  check("shadow_set0", {31'b0, last_ill}, 32'h0);

      step(0, 1, WR, 12'h323, 32'h1, 0, '0);
      for (int i = 0; i < 5; i++) step(0, 0, RD, 12'h000, 32'h0, 0, 2'b01);
      for (int i = 0; i < 5; i++) step(0, 0, RD, 12'h000, 32'h0, 0, 2'b10);
      step(0, 1, RD, 12'hB03, 32'h0, 0, '0);  check("hpm3", last_rdata, HPM_EN ? 32'h5 : 32'h0);
      step(0, 1, RD, 12'hB04, 32'h0, 0, '0);  check("hpm4", last_rdata, 32'h0);
      step(0, 1, RD, 12'hB05, 32'h0, 0, '0);  check("hpm5_hit", {31'b0, last_hit}, HPM_EN ? 32'h0 : 32'h1);

      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, 2'($urandom),
              rand_addr(), rand_wdata(), 1'($urandom), N_HPM'($urandom));
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
